// File: rtl/divclk_uart_tx.sv
// UART transmitter paced by the divider's slow clock: synchronizes it, turns rising
// edges into one-cycle ticks, and shifts out start/data(LSB first)/stop frames.
module divclk_uart_tx #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_SYS_CLOCK,
    input  logic                 i_RESET,
    input  logic                 i_DIV_CLOCK,
    input  logic [DATA_BITS-1:0] i_DATA,
    input  logic                 i_VALID,
    output logic                 o_READY,
    output logic                 o_TX,
    output logic                 o_BUSY,
    output logic                 o_TICK
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   tick;
    logic                   accept;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_DIV_CLOCK};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    assign tick   = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign accept = i_VALID & ready_q;

    // cnt_q counts data bits in DATA and stop intervals in STOP
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    shift_d = i_DATA;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (tick) state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (cnt_q == CW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land with the state register
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_TX    = tx_q;
    assign o_READY = ready_q;
    assign o_BUSY  = busy_q;
    assign o_TICK  = tick;
endmodule

// File: tb/tb_divclk_uart_tx.sv
// Bench for divclk_uart_tx: an 8N1 and an 8N2 instance share one stimulus stream.
module tb_divclk_uart_tx;
    localparam int NREC = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       div = 1'b0;
    logic       valid;
    logic [7:0] data;
    logic       r1, tx1, b1, t1;
    logic       r2, tx2, b2, t2;

    int vectors = 0;
    int errors  = 0;

    bit div_en = 0, div_rand = 0, div_hold = 0;
    int div_half = 4, div_cnt = 0;
    int run = 0;

    logic rec_tx1 [NREC];
    logic rec_tx2 [NREC];
    logic rec_r1  [NREC];
    logic rec_r2  [NREC];
    logic rec_b2  [NREC];

    divclk_uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .SYNC_STAGES(2)) dut1 (
        .i_SYS_CLOCK(clk), .i_RESET(rst), .i_DIV_CLOCK(div), .i_DATA(data),
        .i_VALID(valid), .o_READY(r1), .o_TX(tx1), .o_BUSY(b1), .o_TICK(t1));

    divclk_uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .SYNC_STAGES(2)) dut2 (
        .i_SYS_CLOCK(clk), .i_RESET(rst), .i_DIV_CLOCK(div), .i_DATA(data),
        .i_VALID(valid), .o_READY(r2), .o_TX(tx2), .o_BUSY(b2), .o_TICK(t2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_hold) begin
            div     = 1'b1;
            div_cnt = 0;
        end else if (div_en) begin
            div_cnt++;
            if (div_cnt >= div_half) begin
                div_cnt  = 0;
                div      = ~div;
                div_half = div_rand ? int'($urandom_range(3, 7)) : 4;
            end
        end
    end

    // Reference: a tick follows the 2nd consecutive sampled-high edge
    always @(posedge clk) begin
        if (rst) run = 0;
        else     run = div ? run + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int sel, input int from, input logic v);
        for (int i = (from < 0 ? 0 : from); i < NREC; i++) begin
            case (sel)
                0: if (rec_tx1[i] === v) return i;
                1: if (rec_tx2[i] === v) return i;
                2: if (rec_r1[i]  === v) return i;
                default: if (rec_r2[i] === v) return i;
            endcase
        end
        return -1;
    endfunction

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            rec_tx1[i] = tx1; rec_tx2[i] = tx2;
            rec_r1[i]  = r1;  rec_r2[i]  = r2;  rec_b2[i] = b2;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string nm, input int sel, input int f,
                               input logic [7:0] d, input int nstop);
        logic e, o;
        int   idx;
        for (int i = 0; i < 9 + nstop; i++) begin
            e   = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : 1'b1;
            idx = (f < 0 ? 0 : f) + 4 + 8 * i;
            o   = (sel == 0) ? rec_tx1[idx] : rec_tx2[idx];
            chk($sformatf("%s_bit%0d", nm, i), 32'(o), 32'(e));
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!(r1 === 1'b1 && r2 === 1'b1) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(r1 & r2), 1);
    endtask

    task automatic send_and_check(input logic [7:0] d);
        int f1, f2, ra, rb;
        bit ok;
        wait_ready();
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
        record(120);
        chk("rdy1_after_accept", 32'(rec_r1[0]), 0);
        f1 = find(0, 0, 1'b0);
        chk("start_latency", 32'(f1 >= 1 && f1 <= 10), 1);
        check_frame($sformatf("n1_%02h", d), 0, f1, d, 1);
        ra = find(2, f1, 1'b1);
        chk("rdy1_latency", 32'(ra - f1), 80);
        f2 = find(1, 0, 1'b0);
        check_frame($sformatf("n2_%02h", d), 1, f2, d, 2);
        rb = find(3, f2, 1'b1);
        chk("rdy2_latency", 32'(rb - f2), 88);
        ok = 1;
        for (int i = 0; i < (rb < 0 ? NREC : rb); i++) if (rec_b2[i] !== 1'b1) ok = 0;
        chk("busy2_hold", 32'(ok), 1);
    endtask

    initial begin
        int  nt, k, f1, fb, rr, nfall;
        bit  ok;
        logic [7:0] d;

        rst = 1'b1; valid = 1'b0; data = 8'h00;
        #1;
        chk("rst_tx", 32'(tx1), 1);
        chk("rst_ready", 32'(r1), 1);
        chk("rst_busy", 32'(b1), 0);
        chk("rst_tick", 32'(t1), 0);
        chk("rst_tx2", 32'(tx2), 1);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        div_en = 1;

        // Tick generation: fixed 4/4, then random phases, then held high
        repeat (40) begin
            @(negedge clk);
            chk("tick_fixed", 32'(t1), 32'(run == 2));
        end
        div_rand = 1;
        repeat (120) begin
            @(negedge clk);
            chk("tick_rand", 32'(t2), 32'(run == 2));
        end
        div_hold = 1;
        nt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("tick_hold", 32'(t1), 32'(run == 2));
            if (i >= 10 && t1 === 1'b1) nt++;
        end
        chk("hold_no_tick", 32'(nt), 0);
        div_hold = 0;
        div_rand = 0;
        repeat (20) @(negedge clk);

        send_and_check(8'hA5);
        send_and_check(8'h00);
        repeat (3) send_and_check(8'($urandom));

        // Back-to-back with valid held: 0xFF then 0x00
        wait_ready();
        data  = 8'hFF;
        valid = 1'b1;
        nfall = 0;
        for (int i = 0; i < NREC; i++) begin
            rec_tx1[i] = tx1;
            rec_r1[i]  = r1;
            if (i > 0 && rec_r1[i-1] === 1'b1 && r1 === 1'b0) begin
                nfall++;
                if (nfall == 1) data = 8'h00;
                else            valid = 1'b0;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        f1 = find(0, 0, 1'b0);
        check_frame("bb1", 0, f1, 8'hFF, 1);
        rr = find(2, f1, 1'b1);
        chk("bb_rdy_latency", 32'(rr - f1), 80);
        chk("bb_rdy_pulse", 32'(rec_r1[rr < 0 ? 0 : rr + 1]), 0);
        fb = find(0, rr, 1'b0);
        chk("bb_gap", 32'((fb - (f1 + 72)) >= 9), 1);
        check_frame("bb2", 0, fb, 8'h00, 1);

        // Mid-frame reset during data bit 3 (forced low so the release is visible)
        wait_ready();
        d     = 8'($urandom) & 8'hF7;
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = ~d;
        k = 0;
        while (tx1 !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mr_start", 32'(tx1), 0);
        repeat (35) @(negedge clk);
        chk("mr_bit3", 32'(tx1), 0);
        #2 rst = 1'b1;
        #1;
        chk("mr_tx", 32'(tx1), 1);
        chk("mr_ready", 32'(r1), 1);
        chk("mr_busy", 32'(b1), 0);
        chk("mr_tick", 32'(t1), 0);
        chk("mr_tx2", 32'(tx2), 1);
        @(negedge clk);
        rst = 1'b0;
        ok = 1;
        repeat (60) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || r1 !== 1'b1 || tx2 !== 1'b1) ok = 0;
        end
        chk("mr_quiet", 32'(ok), 1);
        send_and_check(8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
